// File: rtl/mem_request_unit_pkg.sv
// mem_req_pkg: shared state/op encodings and default fill values for the memory request unit
package mem_req_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, DECODE, DATA} state_t;
   typedef enum logic {LOAD, STORE} op_t;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [31:0] ERR_DATA_DEF = 32'hBAD0_BAD0;
endpackage

// File: rtl/mem_request_unit_ack_timeout.sv
// ack_timeout: counts cycles spent waiting for a RAM acknowledge and flags the final allowed cycle
module ack_timeout #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic nRST,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int CW = $clog2(TIMEOUT);
   logic [CW-1:0] cnt;
   assign expired = cnt == CW'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (!nRST || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/mem_request_unit.sv
// mem_request_unit: serialises instruction fetch and data access from a single-cycle core onto one RAM port
module mem_request_unit
   import mem_req_pkg::*;
#(
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter logic [31:0] ERR_DATA  = ERR_DATA_DEF
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic [31:0] imemaddr,
   output logic [31:0] imemload,
   output logic        i_ready,
   input  logic        dmem_ren,
   input  logic        dmem_wen,
   input  logic [31:0] dmemaddr,
   input  logic [31:0] dmemstore,
   output logic [31:0] dmemload,
   output logic        d_ready,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_store,
   output logic        ram_ren,
   output logic        ram_wen,
   input  logic [31:0] ram_load,
   input  logic        ram_ack,
   output logic        bus_err
);
   state_t      state;
   op_t         op;
   logic [31:0] dmem_q;
   logic        busy, expired, done;
   assign busy = state == FETCH || state == DATA;
   assign done = ram_ack || expired;
   ack_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk(clk),
      .nRST(nRST),
      .clr(!busy || done),
      .en(busy),
      .expired(expired)
   );
   assign ram_ren   = state == FETCH || (state == DATA && op == LOAD);
   assign ram_wen   = state == DATA && op == STORE;
   assign ram_addr  = state == FETCH ? imemaddr : state == DATA ? dmemaddr : '0;
   assign ram_store = ram_wen ? dmemstore : '0;
   assign d_ready   = state == DATA && done;
   assign i_ready   = d_ready || (state == DECODE && !(dmem_ren || dmem_wen));
   // a timed-out access reports ERR_DATA even for stores; a completed store keeps the old load value
   assign dmemload  = !d_ready ? dmem_q : !ram_ack ? ERR_DATA : op == LOAD ? ram_load : dmem_q;
   always_ff @(posedge clk) begin
      if (!nRST) begin
         state    <= IDLE;
         op       <= LOAD;
         imemload <= NOP_INSTR;
         dmem_q   <= '0;
         bus_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= FETCH;
            FETCH: if (done) begin
               imemload <= ram_ack ? ram_load : NOP_INSTR;
               bus_err  <= bus_err || !ram_ack;
               state    <= DECODE;
            end
            DECODE: begin
               op    <= dmem_wen ? STORE : LOAD;
               state <= (dmem_ren || dmem_wen) ? DATA : FETCH;
            end
            DATA: if (done) begin
               dmem_q  <= dmemload;
               bus_err <= bus_err || !ram_ack;
               state   <= FETCH;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: expands instruction-level scenarios into a per-cycle schedule and checks the unit every cycle
module tb_mem_request_unit;
   localparam int T = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] ERR = 32'hBAD0_BAD0;
   typedef struct packed {
      logic        nrst, ren, wen, ack, chk;
      logic [31:0] pc, daddr, sdata, rload;
      logic [31:0] e_addr, e_store, e_iload, e_dload;
      logic        e_ren, e_wen, e_ir, e_dr, e_err;
   } cyc_t;
   cyc_t q[$];
   logic        clk = 1'b1;
   logic        nRST, i_ready, dmem_ren, dmem_wen, d_ready, ram_ren, ram_wen, ram_ack, bus_err;
   logic [31:0] imemaddr, imemload, dmemaddr, dmemstore, dmemload, ram_addr, ram_store, ram_load;
   logic [31:0] m_iload, m_dload;
   logic        m_err;
   int          n_chk = 0, n_err = 0;
   always #5 clk = ~clk;
   mem_request_unit #(.TIMEOUT(T)) dut (
      .clk(clk), .nRST(nRST), .imemaddr(imemaddr), .imemload(imemload), .i_ready(i_ready),
      .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .dmemload(dmemload), .d_ready(d_ready), .ram_addr(ram_addr), .ram_store(ram_store),
      .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_load(ram_load), .ram_ack(ram_ack), .bus_err(bus_err)
   );
   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic base(output cyc_t c);
      c = '0;
      c.nrst = 1'b1;
      c.chk = 1'b1;
      c.e_iload = m_iload;
      c.e_dload = m_dload;
      c.e_err = m_err;
   endtask
   task automatic do_reset(int n, bit first_unchecked);
      cyc_t c;
      m_iload = NOP;
      m_dload = '0;
      m_err = 1'b0;
      for (int i = 0; i < n; i++) begin
         base(c);
         c.nrst = 1'b0;
         c.chk = !(first_unchecked && i == 0);
         q.push_back(c);
      end
      base(c);
      q.push_back(c);
   endtask
   // op: 0 none, 1 load, 2 store, 3 both; a latency of 0 means no ack (timeout); abort>0 resets in that data cycle
   task automatic instr(logic [31:0] pc, int flat, logic [31:0] iword, logic [1:0] op, logic [31:0] daddr,
                        logic [31:0] sdata, int dlat, logic [31:0] lword, int abort);
      cyc_t c;
      int   n;
      bit   st;
      n = flat ? flat : T;
      for (int i = 1; i <= n; i++) begin
         base(c);
         {c.pc, c.ren, c.wen, c.daddr, c.sdata} = {pc, op[0], op[1], daddr, sdata};
         c.ack = i == flat;
         c.rload = c.ack ? iword : 32'hA5A5_0000 + i;
         c.e_ren = 1'b1;
         c.e_addr = pc;
         q.push_back(c);
      end
      m_iload = flat ? iword : NOP;
      if (flat == 0) m_err = 1'b1;
      base(c);
      {c.pc, c.ren, c.wen, c.daddr, c.sdata} = {pc, op[0], op[1], daddr, sdata};
      c.ack = 1'b1;
      c.rload = 32'hFFFF_FFFF;
      c.e_ir = op == 2'd0;
      q.push_back(c);
      if (op == 2'd0) return;
      st = op[1];
      n = abort ? abort : (dlat ? dlat : T);
      for (int i = 1; i <= n; i++) begin
         base(c);
         {c.pc, c.ren, c.wen, c.daddr, c.sdata} = {pc, op[0], op[1], daddr, sdata};
         c.ack = i == dlat && abort == 0;
         c.rload = c.ack ? lword : 32'h5A5A_0000 + i;
         c.nrst = !(abort != 0 && i == n);
         c.e_ren = !st;
         c.e_wen = st;
         c.e_addr = daddr;
         c.e_store = st ? sdata : '0;
         c.e_dr = i == n && abort == 0;
         c.e_ir = c.e_dr;
         if (c.e_dr) c.e_dload = dlat == 0 ? ERR : st ? m_dload : lword;
         q.push_back(c);
      end
      if (abort == 0) begin
         m_dload = q[$].e_dload;
         if (dlat == 0) m_err = 1'b1;
      end
   endtask
   initial begin
      int base_i;
      do_reset(2, 1);
      base_i = q.size();
      instr(32'h0000_0000, 1, 32'h0050_0093, 2'd0, 0, 0, 0, 0, 0);
      check("pin_first_decode_iload", q[base_i + 1].e_iload, 32'h0050_0093);
      check("pin_iready_cycle3", {31'd0, q[base_i + 1].e_ir}, 1);
      check("pin_fetch_only_ren", {30'd0, q[base_i].e_ren, q[base_i + 1].e_ren}, 32'd2);
      instr(32'h0000_0004, 2, 32'h0400_2083, 2'd1, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 0);
      check("pin_load_dmemload", q[$].e_dload, 32'hDEAD_BEEF);
      instr(32'h0000_0008, 1, 32'h0010_2023, 2'd2, 32'h0000_0080, 32'h1234_5678, 2, 32'h7777_7777, 0);
      check("pin_store_keeps_dload", q[$].e_dload, 32'hDEAD_BEEF);
      instr(32'h0000_000C, 3, 32'h0020_2223, 2'd3, 32'h0000_0100, 32'hCAFE_F00D, 1, 32'h1111_1111, 0);
      instr(32'h0000_0010, T, 32'h0000_0033, 2'd0, 0, 0, 0, 0, 0);
      check("pin_late_ack_no_err", {31'd0, m_err}, 0);
      instr(32'h0000_0014, 0, 32'h0000_00B3, 2'd0, 0, 0, 0, 0, 0);
      check("pin_fetch_timeout_nop", m_iload, 32'h0000_0013);
      instr(32'h0000_0018, 1, 32'h0000_2103, 2'd1, 32'h0000_0200, 0, 0, 0, 0);
      check("pin_data_timeout_err", q[$].e_dload, 32'hBAD0_BAD0);
      instr(32'h0000_001C, 2, 32'h0000_0133, 2'd0, 0, 0, 0, 0, 0);
      instr(32'h0000_0020, 1, 32'h0030_2023, 2'd2, 32'h0000_0300, 32'h0BAD_F00D, 0, 0, 2);
      do_reset(2, 0);
      instr(32'h0000_0000, 1, 32'h0050_0093, 2'd1, 32'h0000_0044, 0, 1, 32'h0123_4567, 0);
      foreach (q[i]) begin
         {nRST, imemaddr, dmem_ren, dmem_wen, dmemaddr, dmemstore, ram_load, ram_ack} =
            {q[i].nrst, q[i].pc, q[i].ren, q[i].wen, q[i].daddr, q[i].sdata, q[i].rload, q[i].ack};
         @(negedge clk);
         if (q[i].chk) begin
            check($sformatf("c%0d ram_ren", i), ram_ren, q[i].e_ren);
            check($sformatf("c%0d ram_wen", i), ram_wen, q[i].e_wen);
            check($sformatf("c%0d ram_addr", i), ram_addr, q[i].e_addr);
            check($sformatf("c%0d ram_store", i), ram_store, q[i].e_store);
            check($sformatf("c%0d imemload", i), imemload, q[i].e_iload);
            check($sformatf("c%0d dmemload", i), dmemload, q[i].e_dload);
            check($sformatf("c%0d i_ready", i), i_ready, q[i].e_ir);
            check($sformatf("c%0d d_ready", i), d_ready, q[i].e_dr);
            check($sformatf("c%0d bus_err", i), bus_err, q[i].e_err);
         end
         @(posedge clk);
         #1;
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Sits between the single-cycle core and the single-ported RAM. It replaces the core's direct instruction/data RAM hookup.
- Fetches the instruction at the PC, holds it stable while the core executes it, and serialises any load/store onto the same RAM port.
- Paces the core with i_ready (PC may advance) and d_ready (data access complete).
- Adds an acknowledge timeout with a sticky bus error flag.

Parameters:
- TIMEOUT, 16: max cycles waiting for ram_ack before abort; must be ≥2.
- NOP_INSTR, 32'h0000_0013: instruction substituted on fetch timeout and at reset.
- ERR_DATA, 32'hBAD0_BAD0: dmemload value returned on a data timeout.

Ports:
- clk  in  1  system clock, rising edge
- nRST  in  1  synchronous active-low reset
- imemaddr  in  32  PC value to fetch
- imemload  out  32  latched instruction, stable from DECODE until next FETCH ack
- i_ready  out  1  one-cycle pulse: instruction complete, PC and register file may update
- dmem_ren  in  1  load request (control memRead), sampled in DECODE
- dmem_wen  in  1  store request (control memWrite), sampled in DECODE
- dmemaddr  in  32  data address (ALU result)
- dmemstore  in  32  store data (regData2)
- dmemload  out  32  load data, valid when d_ready=1
- d_ready  out  1  one-cycle pulse: data access complete
- ram_addr  out  32  RAM address
- ram_store  out  32  RAM write data
- ram_ren  out  1  RAM read strobe
- ram_wen  out  1  RAM write strobe
- ram_load  in  32  RAM read data, valid with ram_ack
- ram_ack  in  1  RAM completes current access this cycle
- bus_err  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- States: IDLE, FETCH, DECODE, DATA.
- Reset (nRST=0 at a rising edge): state=IDLE, imemload=NOP_INSTR, timeout counter=0, bus_err=0. All strobes and ready signals are 0; ram_addr, ram_store and dmemload are 0.
- Reset mid-access drops ram_ren/ram_wen on that same edge. No completion pulse is emitted.
- IDLE: no outputs; always goes to FETCH next cycle.
- FETCH:
  - ram_ren=1, ram_addr=imemaddr, ram_wen=0.
  - On ram_ack: imemload<=ram_load, go DECODE.
  - Counter increments each cycle without ack. When it reaches TIMEOUT-1 without ack: imemload<=NOP_INSTR, bus_err<=1, go DECODE.
  - Minimum fetch latency: 1 cycle (ack in the first FETCH cycle).
- DECODE:
  - Lasts exactly one cycle; imemload is stable; no RAM strobes; counter cleared.
  - If dmem_wen|dmem_ren: go DATA and latch op type (store if dmem_wen=1; write has priority when both are set).
  - Else: i_ready=1 this cycle, go FETCH.
- DATA:
  - ram_addr=dmemaddr. Store: ram_wen=1, ram_store=dmemstore. Load: ram_ren=1.
  - On ram_ack: d_ready=1 and i_ready=1 in the same cycle, go FETCH. For a load, dmemload=ram_load combinationally in that cycle.
  - Timeout after TIMEOUT cycles: d_ready=1, i_ready=1, dmemload=ERR_DATA, bus_err<=1, go FETCH. A timed-out store is considered lost.
- dmemload outside a d_ready cycle: holds its last value (registered copy updated on completion).
- imemaddr and dmemaddr are sampled combinationally each cycle. The core must hold PC stable between i_ready pulses.
- ram_ack while not in FETCH or DATA is ignored.
- Integration rule: the core gates register writes and PC update with i_ready.
- Throughput: non-memory instruction = fetch latency + 1 cycle; memory instruction = fetch latency + 1 + data latency.
- Counter is wide enough for TIMEOUT (clog2). It never wraps; it clears on every state change.

Decomposition:
- Package mem_req_pkg: state enum (IDLE, FETCH, DECODE, DATA), op-type enum (LOAD, STORE), NOP_INSTR and ERR_DATA defaults.
- Sub-module ack_timeout: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT. The FSM stays in the parent.

Test Plan:
- Reset, then ack in the first FETCH cycle with ram_load=32'h0050_0093 and no mem op → imemload=32'h0050_0093 in DECODE; i_ready pulses on cycle 3 after reset release; ram_ren high only in the FETCH cycle.
- Load: dmem_ren=1, dmemaddr=32'h0000_0040, ack after 3 cycles with ram_load=32'hDEAD_BEEF → ram_addr=32'h40 during DATA; d_ready=i_ready=1 with dmemload=32'hDEAD_BEEF; next state FETCH.
- Store: dmem_wen=1, dmemstore=32'h1234_5678, ack after 2 cycles → ram_wen=1 and ram_store=32'h1234_5678 for both DATA cycles; ram_ren=0; d_ready pulses once.
- Timeouts: no ack during FETCH for 16 cycles → imemload=32'h0000_0013, bus_err=1. Then a load with no ack → dmemload=32'hBAD0_BAD0, bus_err stays 1 until nRST.
- Both dmem_ren and dmem_wen high in DECODE → store performed (ram_wen=1, ram_ren=0).
- Drive nRST=0 during the second DATA cycle → next edge: strobes 0, d_ready/i_ready never pulse, state IDLE, imemload=NOP_INSTR.
